// File: rtl/cpu_imem_responder.sv
// Instruction-bus responder with a private word array, configurable wait states and a one-cycle ack.
// Define IMEM_WRITE_EN to compile in the byte-masked write path; otherwise the array is read-only.
module cpu_imem_responder #(
  parameter int unsigned p_depth_log2  = 10,
  parameter int unsigned p_wait_states = 0,
  parameter              p_init_file   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] ibus_addr,
  input  logic [3:0]  ibus_be,
  input  logic        ibus_wr_en,
  input  logic [31:0] ibus_wr_data,
  input  logic        ibus_rd_en,
  output logic [31:0] ibus_rd_data,
  output logic        ibus_busy,
  output logic        ibus_ack
);

  localparam int unsigned DEPTH = 1 << p_depth_log2;
  localparam logic [3:0]  WS    = 4'(p_wait_states);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [p_depth_log2-1:0] addr_q;
  logic [3:0]              be_q;
  logic [31:0]             wdata_q;
  logic                    wr_q;

  logic [31:0] mem [DEPTH];

  logic                    req_d;
  logic                    accept_d;
  logic                    acc_en_d;
  logic                    acc_wr_d;
  logic [p_depth_log2-1:0] acc_addr_d;
  logic [3:0]              acc_be_d;
  logic [31:0]             acc_data_d;

  // With no wait states the access uses the live request; otherwise the latched copy.
  always_comb begin
    req_d    = ibus_rd_en | ibus_wr_en;
    accept_d = req_d && (state_q != WAIT);
    if (WS == 4'd0) begin
      acc_en_d   = accept_d;
      acc_wr_d   = ibus_wr_en;
      acc_addr_d = ibus_addr[p_depth_log2+1:2];
      acc_be_d   = ibus_be;
      acc_data_d = ibus_wr_data;
    end else begin
      acc_en_d   = (state_q == WAIT) && (cnt_q == 4'd1);
      acc_wr_d   = wr_q;
      acc_addr_d = addr_q;
      acc_be_d   = be_q;
      acc_data_d = wdata_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      ibus_rd_data <= '0;
      ibus_busy    <= 1'b0;
      ibus_ack     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept_d) begin
            addr_q  <= ibus_addr[p_depth_log2+1:2];
            be_q    <= ibus_be;
            wdata_q <= ibus_wr_data;
            wr_q    <= ibus_wr_en;
            if (WS == 4'd0) begin
              state_q   <= RESP;
              ibus_ack  <= 1'b1;
              ibus_busy <= 1'b0;
            end else begin
              state_q   <= WAIT;
              cnt_q     <= WS;
              ibus_ack  <= 1'b0;
              ibus_busy <= 1'b1;
            end
          end else begin
            state_q   <= IDLE;
            ibus_ack  <= 1'b0;
            ibus_busy <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q   <= RESP;
            cnt_q     <= '0;
            ibus_ack  <= 1'b1;
            ibus_busy <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - 4'd1;
            ibus_busy <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          ibus_ack  <= 1'b0;
          ibus_busy <= 1'b0;
        end
      endcase
      if (acc_en_d && !acc_wr_d) ibus_rd_data <= mem[acc_addr_d];
    end
  end

`ifdef IMEM_WRITE_EN
  always_ff @(posedge i_clk) begin
    if (i_rst_n && acc_en_d && acc_wr_d) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_be_d[i]) mem[acc_addr_d][i*8 +: 8] <= acc_data_d[i*8 +: 8];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ibus_addr[1:0], ibus_addr[31:p_depth_log2+2]};
`else
  logic unused_bits;
  assign unused_bits = ^{ibus_addr[1:0], ibus_addr[31:p_depth_log2+2],
                         acc_be_d, acc_data_d};
`endif

endmodule

// File: tb/tb_cpu_imem_responder.sv
// Scoreboard bench: u0 has no wait states and 16 words, u1 has two wait states and 1024 words.
module tb_cpu_imem_responder;

`ifdef IMEM_WRITE_EN
  localparam logic [31:0] EXP_W1 = 32'h1122CCDD;
  localparam logic [31:0] EXP_W2 = 32'h01020304;
`else
  localparam logic [31:0] EXP_W1 = 32'h11223344;
  localparam logic [31:0] EXP_W2 = 32'h55667788;
`endif

  logic        clk;
  logic        rst_n   [2];
  logic [31:0] addr    [2];
  logic [3:0]  be      [2];
  logic        wr_en   [2];
  logic [31:0] wr_data [2];
  logic        rd_en   [2];
  logic [31:0] rd_data [2];
  logic        busy    [2];
  logic        ack     [2];

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  cpu_imem_responder #(.p_depth_log2(4), .p_wait_states(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .ibus_addr(addr[0]), .ibus_be(be[0]),
    .ibus_wr_en(wr_en[0]), .ibus_wr_data(wr_data[0]), .ibus_rd_en(rd_en[0]),
    .ibus_rd_data(rd_data[0]), .ibus_busy(busy[0]), .ibus_ack(ack[0]));

  cpu_imem_responder #(.p_depth_log2(10), .p_wait_states(2)) u1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .ibus_addr(addr[1]), .ibus_be(be[1]),
    .ibus_wr_en(wr_en[1]), .ibus_wr_data(wr_data[1]), .ibus_rd_en(rd_en[1]),
    .ibus_rd_data(rd_data[1]), .ibus_busy(busy[1]), .ibus_ack(ack[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // Monitor: every ack pops one expected rd_data value.
  always @(negedge clk) begin
    if (rst_n[0] && ack[0]) begin
      chk("u0_ack_busy_overlap", {31'b0, busy[0]}, 32'd0);
      if (sb0.size() == 0) chk("u0_unexpected_ack", 32'd1, 32'd0);
      else chk("u0_rd_data", rd_data[0], sb0.pop_front());
    end
    if (rst_n[1] && ack[1]) begin
      chk("u1_ack_busy_overlap", {31'b0, busy[1]}, 32'd0);
      if (sb1.size() == 0) chk("u1_unexpected_ack", 32'd1, 32'd0);
      else chk("u1_rd_data", rd_data[1], sb1.pop_front());
    end
  end

  task automatic drive(input int u, input logic [31:0] a, input logic rd, input logic wr,
                       input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp);
    int n = 0;
    while (busy[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy[u]) chk("busy_timeout", 32'd1, 32'd0);
    addr[u] = a; rd_en[u] = rd; wr_en[u] = wr; be[u] = b; wr_data[u] = d;
    if (u == 0) sb0.push_back(exp);
    else        sb1.push_back(exp);
    @(negedge clk);
  endtask

  task automatic idle(input int u);
    rd_en[u] = 1'b0;
    wr_en[u] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; addr[u] = '0; be[u] = '0; wr_en[u] = 1'b0;
      wr_data[u] = '0; rd_en[u] = 1'b0;
    end
    u0.mem[0] = 32'hDEADBEEF;
    u0.mem[1] = 32'h11223344;
    u0.mem[2] = 32'h55667788;
    u0.mem[4] = 32'h00000013;
    u1.mem[4] = 32'h00000013;
    u1.mem[5] = 32'hCAFEF00D;

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_rd_data", rd_data[u], 32'd0);
      chk("reset_busy", {31'b0, busy[u]}, 32'd0);
      chk("reset_ack", {31'b0, ack[u]}, 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // u0: zero wait states, one-cycle response, busy never high.
    drive(0, 32'h10, 1, 0, 4'h0, 32'h0, 32'h00000013);
    chk("u0_ack_after_one", {31'b0, ack[0]}, 32'd1);
    chk("u0_busy_low", {31'b0, busy[0]}, 32'd0);
    drive(0, 32'h0, 1, 0, 4'h0, 32'h0, 32'hDEADBEEF);
    drive(0, 32'h4, 1, 0, 4'h0, 32'h0, 32'h11223344);
    chk("u0_b2b_ack1", {31'b0, ack[0]}, 32'd1);
    drive(0, 32'h8, 1, 0, 4'h0, 32'h0, 32'h55667788);
    chk("u0_b2b_ack2", {31'b0, ack[0]}, 32'd1);
    drive(0, 32'h40, 1, 0, 4'h0, 32'h0, 32'hDEADBEEF);
    chk("u0_b2b_ack3", {31'b0, ack[0]}, 32'd1);
    drive(0, 32'h4, 0, 1, 4'b0011, 32'hAABBCCDD, 32'hDEADBEEF);
    drive(0, 32'h4, 1, 0, 4'h0, 32'h0, EXP_W1);
    drive(0, 32'h8, 1, 1, 4'b1111, 32'h01020304, EXP_W1);
    drive(0, 32'h8, 1, 0, 4'h0, 32'h0, EXP_W2);
    idle(0);
    @(negedge clk);
    chk("u0_idle_no_ack", {31'b0, ack[0]}, 32'd0);
    chk("u0_rd_data_held", rd_data[0], EXP_W2);

    // u1: two wait states; a read pulse during busy must be ignored.
    addr[1] = 32'h10; rd_en[1] = 1'b1;
    sb1.push_back(32'h00000013);
    @(negedge clk);
    chk("u1_busy_c1", {31'b0, busy[1]}, 32'd1);
    chk("u1_no_ack_c1", {31'b0, ack[1]}, 32'd0);
    addr[1] = 32'h14;
    @(negedge clk);
    chk("u1_busy_c2", {31'b0, busy[1]}, 32'd1);
    idle(1);
    @(negedge clk);
    chk("u1_ack_c3", {31'b0, ack[1]}, 32'd1);
    chk("u1_busy_c3", {31'b0, busy[1]}, 32'd0);
    @(negedge clk);
    chk("u1_pulse_ignored", {31'b0, ack[1] | busy[1]}, 32'd0);

    drive(1, 32'h14, 1, 0, 4'h0, 32'h0, 32'hCAFEF00D);
    drive(1, 32'h10, 1, 0, 4'h0, 32'h0, 32'h00000013);
    drive(1, 32'h1014, 1, 0, 4'h0, 32'h0, 32'hCAFEF00D);
    idle(1);
    repeat (4) @(negedge clk);

    // u1: reset during the wait of a write discards it.
    addr[1] = 32'h14; wr_en[1] = 1'b1; be[1] = 4'b1111; wr_data[1] = 32'h12345678;
    @(negedge clk);
    idle(1);
    chk("u1_wait_busy", {31'b0, busy[1]}, 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk("u1_rst_busy", {31'b0, busy[1]}, 32'd0);
    chk("u1_rst_ack", {31'b0, ack[1]}, 32'd0);
    chk("u1_rst_rd_data", rd_data[1], 32'd0);
    repeat (3) @(negedge clk);
    chk("u1_rst_no_ack", {31'b0, ack[1]}, 32'd0);
    rst_n[1] = 1'b1;
    drive(1, 32'h14, 1, 0, 4'h0, 32'h0, 32'hCAFEF00D);
    idle(1);
    chk("u1_post_rst_busy", {31'b0, busy[1]}, 32'd1);

    repeat (6) @(negedge clk);
    chk("u0_pending", 32'(sb0.size()), 32'd0);
    chk("u1_pending", 32'(sb1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
